// File: rtl/masked_rand_sched.sv
// masked_rand_sched: seeds an external PRNG, discards warm-up steps, then deals
// one fresh PRNG word per round-robin grant until a reseed is due.
module masked_rand_sched #(
    parameter int NUM_REQ = 4,
    parameter int WARMUP_CYCLES = 128,
    parameter int RESEED_INTERVAL = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_valid_i,
    input  logic [127:0]       seed_i,
    output logic               seed_ready_o,
    output logic               seed_err_o,
    output logic               reseed_req_o,
    output logic               prng_init_o,
    output logic               prng_en_o,
    output logic [127:0]       prng_seed_o,
    input  logic [127:0]       prng_data_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    output logic [127:0]       rand_o
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {UNSEEDED, LOAD, WARMUP, READY} state_t;

    state_t        state, state_nx;
    logic [127:0]  seed_q;
    logic [15:0]   draw_cnt;
    logic [7:0]    warm_cnt;
    logic [IW-1:0] ptr, gidx, idx;
    logic          err_q, hit, grant, seed_xfer, seed_nz;

    assign seed_ready_o = !rst && (state == UNSEEDED || state == READY);
    assign seed_xfer    = seed_valid_i && seed_ready_o;
    assign seed_nz      = |seed_i;
    assign seed_err_o   = err_q;
    assign reseed_req_o = state == UNSEEDED;
    assign prng_init_o  = state == LOAD;
    assign prng_seed_o  = seed_q;
    assign grant        = state == READY && !seed_xfer && hit;
    assign prng_en_o    = state == WARMUP || grant;
    assign req_ready_o  = grant ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx : '0;
    assign rand_o       = rst ? '0 : prng_data_i;

    // Descending scan so the requester closest to ptr is the last to overwrite gidx
    always_comb begin
        hit  = 1'b0;
        gidx = ptr;
        idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % NUM_REQ);
            if (req_valid_i[idx]) begin
                hit  = 1'b1;
                gidx = idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            UNSEEDED: state_nx = (seed_xfer && seed_nz) ? LOAD : UNSEEDED;
            LOAD:     state_nx = WARMUP;
            WARMUP:   state_nx = (warm_cnt == 8'(WARMUP_CYCLES - 1)) ? READY : WARMUP;
            READY:    state_nx = (seed_xfer && seed_nz) ? LOAD :
                                 (grant && draw_cnt == 16'(RESEED_INTERVAL - 1)) ? UNSEEDED : READY;
            default:  state_nx = UNSEEDED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= UNSEEDED;
            seed_q   <= '0;
            draw_cnt <= '0;
            warm_cnt <= '0;
            ptr      <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            err_q    <= seed_xfer && !seed_nz;
            warm_cnt <= (state == WARMUP) ? warm_cnt + 8'd1 : '0;
            if (seed_xfer && seed_nz) begin
                seed_q   <= seed_i;
                draw_cnt <= '0;
            end else if (state == LOAD) begin
                seed_q <= '0;
            end
            if (grant) begin
                draw_cnt <= draw_cnt + 16'd1;
                ptr      <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_masked_rand_sched.sv
// tb_masked_rand_sched: directed table of vectors driven into two instances
// (default reseed interval and interval 4) sharing the same inputs.
module tb_masked_rand_sched;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         seed_valid_i = 1'b0;
    logic [127:0] seed_i = '0;
    logic [3:0]   req_valid_i = '0;
    logic         sr, err, rr, ini, en, sr4, err4, rr4, ini4, en4;
    logic [127:0] ps, ps4, pd, pd4, rnd, rnd4, last, last4;
    logic [3:0]   g, g4;
    int           vectors = 0, miscompares = 0, overlap = 0;

    localparam logic [127:0] S  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] S2 = 128'hDEADBEEF00000000CAFEF00D12345678;
    localparam logic [127:0] S3 = 128'h00000000000000000000000000000001;
    localparam logic [127:0] K  = 128'h9E3779B97F4A7C15F39CC0605CEDC835;

    // {seed_ready, seed_err, reseed_req, prng_init, prng_en, req_ready[3:0]}
    localparam logic [8:0] RST  = 9'b0_0_1_0_0_0000;
    localparam logic [8:0] UID  = 9'b1_0_1_0_0_0000;
    localparam logic [8:0] UER  = 9'b1_1_1_0_0_0000;
    localparam logic [8:0] LD   = 9'b0_0_0_1_0_0000;
    localparam logic [8:0] WM   = 9'b0_0_0_0_1_0000;
    localparam logic [8:0] RID  = 9'b1_0_0_0_0_0000;
    localparam logic [8:0] G0   = 9'b1_0_0_0_1_0001;
    localparam logic [8:0] G1   = 9'b1_0_0_0_1_0010;
    localparam logic [8:0] G2   = 9'b1_0_0_0_1_0100;
    localparam logic [8:0] G3   = 9'b1_0_0_0_1_1000;
    localparam logic [8:0] G2E  = 9'b1_1_0_0_1_0100;

    masked_rand_sched dut (
        .clk(clk), .rst(rst), .seed_valid_i(seed_valid_i), .seed_i(seed_i),
        .seed_ready_o(sr), .seed_err_o(err), .reseed_req_o(rr), .prng_init_o(ini),
        .prng_en_o(en), .prng_seed_o(ps), .prng_data_i(pd), .req_valid_i(req_valid_i),
        .req_ready_o(g), .rand_o(rnd)
    );

    masked_rand_sched #(.RESEED_INTERVAL(4)) dut4 (
        .clk(clk), .rst(rst), .seed_valid_i(seed_valid_i), .seed_i(seed_i),
        .seed_ready_o(sr4), .seed_err_o(err4), .reseed_req_o(rr4), .prng_init_o(ini4),
        .prng_en_o(en4), .prng_seed_o(ps4), .prng_data_i(pd4), .req_valid_i(req_valid_i),
        .req_ready_o(g4), .rand_o(rnd4)
    );

    always #5 clk = ~clk;

    // Stand-in PRNG: loads on init, advances by a large odd constant per step
    initial begin
        pd  = '0;
        pd4 = '0;
    end
    always @(posedge clk) begin
        if (ini) pd <= ps; else if (en) pd <= pd + K;
        if (ini4) pd4 <= ps4; else if (en4) pd4 <= pd4 + K;
        if ((ini && en) || (ini4 && en4)) overlap <= overlap + 1;
    end

    typedef struct {
        logic         r;
        logic         sv;
        logic [127:0] sd;
        logic [3:0]   rq;
        int           n;
        logic [127:0] ps;
        logic [8:0]   e;
        logic [8:0]   e4;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic sv, logic [127:0] sd, logic [3:0] rq,
                                int n, logic [127:0] p, logic [8:0] e, logic [8:0] e4);
        vec_t t;
        t.r = r; t.sv = sv; t.sd = sd; t.rq = rq; t.n = n; t.ps = p; t.e = e; t.e4 = e4;
        return t;
    endfunction

    task automatic chk(input string nm, input int v, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %h want %h", nm, v, got, exp);
        end
    endtask

    initial begin
        tbl.push_back(mk(1, 0, '0, 4'b0000,   2, '0, RST, RST));
        tbl.push_back(mk(0, 1, '0, 4'b0000,   1, '0, UID, UID));
        tbl.push_back(mk(0, 0, '0, 4'b0000,   1, '0, UER, UER));
        tbl.push_back(mk(0, 0, '0, 4'b0000,   1, '0, UID, UID));
        tbl.push_back(mk(0, 1, S,  4'b1111,   1, '0, UID, UID));
        tbl.push_back(mk(0, 0, '0, 4'b1111,   1, S,  LD,  LD));
        tbl.push_back(mk(0, 0, '0, 4'b1111, 128, '0, WM,  WM));
        tbl.push_back(mk(0, 0, '0, 4'b1111,   1, '0, G0,  G0));
        tbl.push_back(mk(0, 0, '0, 4'b1111,   1, '0, G1,  G1));
        tbl.push_back(mk(0, 0, '0, 4'b1111,   1, '0, G2,  G2));
        tbl.push_back(mk(0, 0, '0, 4'b1111,   1, '0, G3,  G3));
        tbl.push_back(mk(0, 0, '0, 4'b1111,   1, '0, G0,  UID));
        tbl.push_back(mk(0, 0, '0, 4'b1111,   1, '0, G1,  UID));
        tbl.push_back(mk(0, 0, '0, 4'b1111,   1, '0, G2,  UID));
        tbl.push_back(mk(0, 0, '0, 4'b1111,   1, '0, G3,  UID));
        tbl.push_back(mk(0, 1, S2, 4'b0010,   1, '0, RID, UID));
        tbl.push_back(mk(0, 0, '0, 4'b0000,   1, S2, LD,  LD));
        tbl.push_back(mk(0, 0, '0, 4'b1111, 128, '0, WM,  WM));
        tbl.push_back(mk(0, 0, '0, 4'b0010,   1, '0, G1,  G1));
        tbl.push_back(mk(0, 0, '0, 4'b0101,   1, '0, G2,  G2));
        tbl.push_back(mk(0, 0, '0, 4'b0101,   1, '0, G0,  G0));
        tbl.push_back(mk(0, 0, '0, 4'b0011,   1, '0, G1,  G1));
        tbl.push_back(mk(0, 1, '0, 4'b1111,   1, '0, RID, UID));
        tbl.push_back(mk(0, 0, '0, 4'b1111,   1, '0, G2E, UER));
        tbl.push_back(mk(0, 0, '0, 4'b0000,   1, '0, RID, UID));
        tbl.push_back(mk(0, 1, S3, 4'b0000,   1, '0, RID, UID));
        tbl.push_back(mk(0, 0, '0, 4'b0000,   1, S3, LD,  LD));
        tbl.push_back(mk(0, 0, '0, 4'b1111,  50, '0, WM,  WM));
        tbl.push_back(mk(1, 1, S,  4'b1111,   2, '0, RST, RST));
        tbl.push_back(mk(0, 0, '0, 4'b1111,   3, '0, UID, UID));

        last  = '0;
        last4 = '0;
        @(posedge clk);
        #1;
        foreach (tbl[v]) begin
            for (int c = 0; c < tbl[v].n; c++) begin
                rst          = tbl[v].r;
                seed_valid_i = tbl[v].sv;
                seed_i       = tbl[v].sd;
                req_valid_i  = tbl[v].rq;
                @(negedge clk);
                chk("ctrl", v, 128'({sr, err, rr, ini, en, g}), 128'(tbl[v].e));
                chk("ctrl4", v, 128'({sr4, err4, rr4, ini4, en4, g4}), 128'(tbl[v].e4));
                chk("seed", v, ps, tbl[v].ps);
                chk("seed4", v, ps4, tbl[v].ps);
                if (tbl[v].e[3:0] != 4'b0000) begin
                    chk("rand", v, rnd, pd);
                    vectors++;
                    if (rnd === last) begin
                        miscompares++;
                        $display("FAIL rand_repeat vec %0d: got %h again, want a fresh word", v, rnd);
                    end
                    last = rnd;
                end
                if (tbl[v].e4[3:0] != 4'b0000) begin
                    chk("rand4", v, rnd4, pd4);
                    vectors++;
                    if (rnd4 === last4) begin
                        miscompares++;
                        $display("FAIL rand4_repeat vec %0d: got %h again, want a fresh word", v, rnd4);
                    end
                    last4 = rnd4;
                end
                @(posedge clk);
                #1;
            end
        end
        chk("init_en_overlap", 0, 128'(overlap), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/masked_rand_sched.md
MASKED_RAND_SCHED -- requirements
Module: masked_rand_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of randomness requesters (2..8).
REQ-002 Parameter WARMUP_CYCLES, default 128: PRNG steps discarded after each seed load (1..255).
REQ-003 Parameter RESEED_INTERVAL, default 1024: grants served per seed before forced reseed (1..65535).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 seed_valid_i  input  1  seed_i carries a seed offer.
REQ-007 seed_i  input  128  seed value.
REQ-008 seed_ready_o  output  1  seed accepted this cycle when seed_valid_i also high.
REQ-009 seed_err_o  output  1  one-cycle pulse: all-zero seed rejected.
REQ-010 reseed_req_o  output  1  high while block holds no usable seed.
REQ-011 prng_init_o  output  1  PRNG load strobe.
REQ-012 prng_en_o  output  1  PRNG step enable.
REQ-013 prng_seed_o  output  128  seed driven to PRNG.
REQ-014 prng_data_i  input  128  current PRNG state word.
REQ-015 req_valid_i  input  NUM_REQ  per-requester randomness request.
REQ-016 req_ready_o  output  NUM_REQ  one-hot grant; word transferred when valid and ready both high.
REQ-017 rand_o  output  128  equals prng_data_i; meaningful only in a grant cycle.

Function
REQ-018 FSM states SHALL be UNSEEDED, LOAD, WARMUP, READY; encoding free.
REQ-019 UNSEEDED: seed_ready_o=1, reseed_req_o=1, no grants, prng_en_o=0.
REQ-020 Seed transfer (seed_valid_i & seed_ready_o) with seed_i!=0 SHALL register seed_i into seed_q and go to LOAD next cycle.
REQ-021 Seed transfer with seed_i==0 SHALL pulse seed_err_o next cycle, leave state and seed_q unchanged.
REQ-022 LOAD lasts exactly one cycle: prng_init_o=1, prng_seed_o=seed_q; next state WARMUP, seed_q cleared to 0 on exit.
REQ-023 prng_seed_o SHALL equal seed_q in all states (0 except between accept and LOAD exit).
REQ-024 WARMUP: prng_en_o=1 for exactly WARMUP_CYCLES consecutive cycles, no grants, seed_ready_o=0; then READY.
REQ-025 READY: seed_ready_o=1; if any req_valid_i bit set and no seed transfer this cycle, grant exactly one requester, assert prng_en_o=1 same cycle.
REQ-026 Arbitration SHALL be round-robin: search starts at index (last granted + 1) mod NUM_REQ; pointer resets to 0 (requester 0 first).
REQ-027 req_ready_o SHALL be 0 for non-requesting indices and in every state other than READY.
REQ-028 No two grants SHALL observe the same PRNG word: each grant steps the PRNG; back-to-back grants allowed every cycle.
REQ-029 draw_cnt (16 bit) increments per grant, cleared on every seed accept; grant bringing draw_cnt to RESEED_INTERVAL SHALL be served, then state goes UNSEEDED next cycle.
REQ-030 Seed transfer in READY (voluntary reseed) SHALL take priority over grants that cycle: no grant, go LOAD; zero seed in READY pulses seed_err_o and stays READY with grants suppressed that cycle only.
REQ-031 prng_init_o and prng_en_o SHALL never be high in the same cycle.
REQ-032 Requester may drop req_valid_i without a grant; no state kept per requester beyond RR pointer.

Reset
REQ-033 On rst: state=UNSEEDED, seed_q=0, draw_cnt=0, warmup counter=0, RR pointer=0, seed_err_o=0.
REQ-034 While rst high all outputs SHALL be 0 except reseed_req_o=1; seed_ready_o rises first cycle after release.
REQ-035 rst mid-WARMUP or mid-READY SHALL abort immediately; prior seed is not reused.

Verification
REQ-036 Reset release, seed 0x0123..CDEF valid one cycle -> seed_ready_o=1, next cycle prng_init_o=1 with prng_seed_o=seed, then 128 cycles prng_en_o=1, then READY, seed_q reads 0.
REQ-037 Seed 0 offered in UNSEEDED -> seed_err_o one-cycle pulse, state stays UNSEEDED, prng_init_o never asserted.
REQ-038 READY, req_valid_i=4'b1111 for 8 cycles -> grants 0,1,2,3,0,1,2,3 one-hot, prng_en_o=1 each cycle, rand_o differs each grant.
REQ-039 RESEED_INTERVAL=4, continuous requests -> exactly 4 grants, then reseed_req_o=1, no further grants until new seed and warmup.
REQ-040 READY with req_valid_i=4'b0010 and nonzero seed_valid_i same cycle -> no grant, LOAD next cycle, draw_cnt=0.
REQ-041 rst pulsed at warmup cycle 50 -> all outputs 0 except reseed_req_o=1; after release, new seed required before any grant.
